// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered full adder.
// The master drives operands and the valid strobe; the slave returns the registered result.
interface full_adder_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             in_valid;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             out_valid;

    modport master (
        output a, b, cin, in_valid,
        input  sum, carry, out_valid
    );

    modport slave (
        input  a, b, cin, in_valid,
        output sum, carry, out_valid
    );
endinterface

// File: rtl/full_adder.sv
// Registered ripple-carry full adder: {carry, sum} = a + b + cin, one cycle after in_valid.
// Results hold while in_valid is low; only out_valid drops.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    full_adder_if.slave bus
);

    logic [WIDTH:0]   result_s;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             out_valid_r;

    function automatic logic cell_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic cell_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    // Chains WIDTH single-bit cells; a local running carry avoids a self-referencing vector.
    function automatic logic [WIDTH:0] ripple_add(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             c0
    );
        logic [WIDTH-1:0] s;
        logic             c;
        s = '0;
        c = c0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i] = cell_sum(x[i], y[i], c);
            c    = cell_carry(x[i], y[i], c);
        end
        return {c, s};
    endfunction

    // Combinational ripple chain feeding the result registers.
    always_comb begin
        result_s = ripple_add(bus.a, bus.b, bus.cin);
    end

    // Result registers: reset wins, capture only when qualified, otherwise hold the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r       <= '0;
            carry_r     <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (bus.in_valid) begin
            sum_r       <= result_s[WIDTH-1:0];
            carry_r     <= result_s[WIDTH];
            out_valid_r <= 1'b1;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.sum       = sum_r;
    assign bus.carry     = carry_r;
    assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=1 and WIDTH=8 against an arithmetic reference model.
module tb_full_adder;

    logic clk;
    logic rst;

    full_adder_if #(.WIDTH(1)) bus1 ();
    full_adder_if #(.WIDTH(8)) bus8 ();

    full_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    full_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    int n_checks;
    int n_pass;

    logic       m1_sum, m1_carry, m1_ov;
    logic [7:0] m8_sum;
    logic       m8_carry, m8_ov;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: update the reference model from the inputs seen at the edge, then compare.
    task automatic cycle();
        logic [1:0] r2;
        logic [8:0] r9;
        @(posedge clk);
        if (rst) begin
            m1_sum = 1'b0; m1_carry = 1'b0; m1_ov = 1'b0;
            m8_sum = 8'h00; m8_carry = 1'b0; m8_ov = 1'b0;
        end else begin
            if (bus1.in_valid) begin
                r2 = 2'(bus1.a) + 2'(bus1.b) + 2'(bus1.cin);
                m1_sum = r2[0]; m1_carry = r2[1]; m1_ov = 1'b1;
            end else begin
                m1_ov = 1'b0;
            end
            if (bus8.in_valid) begin
                r9 = 9'(bus8.a) + 9'(bus8.b) + 9'(bus8.cin);
                m8_sum = r9[7:0]; m8_carry = r9[8]; m8_ov = 1'b1;
            end else begin
                m8_ov = 1'b0;
            end
        end
        #1;
        check_eq("w1_ov", 64'(bus1.out_valid), 64'(m1_ov));
        check_eq("w8_ov", 64'(bus8.out_valid), 64'(m8_ov));
        if (m1_ov) begin
            check_eq("w1_sum", 64'(bus1.sum), 64'(m1_sum));
            check_eq("w1_carry", 64'(bus1.carry), 64'(m1_carry));
        end
        if (m8_ov) begin
            check_eq("w8_sum", 64'(bus8.sum), 64'(m8_sum));
            check_eq("w8_carry", 64'(bus8.carry), 64'(m8_carry));
        end
    endtask

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
        bus8.in_valid = v; bus8.a = a; bus8.b = b; bus8.cin = c;
    endtask

    initial begin
        logic [2:0] tt;
        logic       hold_toggle;
        n_checks = 0;
        n_pass   = 0;

        // Reset for two cycles with live, valid inputs that must be discarded.
        rst = 1'b1;
        bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1;
        drive8(1'b1, 8'h01, 8'h01, 1'b1);
        for (int i = 0; i < 2; i++) begin
            cycle();
            check_eq("rst_w1_sum", 64'(bus1.sum), 64'h0);
            check_eq("rst_w1_carry", 64'(bus1.carry), 64'h0);
            check_eq("rst_w8_sum", 64'(bus8.sum), 64'h0);
            check_eq("rst_w8_carry", 64'(bus8.carry), 64'h0);
        end
        rst = 1'b0;
        drive8(1'b0, 8'h00, 8'h00, 1'b0);

        // Single-bit truth table, back to back: (a,b,cin) = 000,010,100,110,001,011,101,111.
        for (int i = 0; i < 8; i++) begin
            tt = 3'(i);
            bus1.in_valid = 1'b1; bus1.a = tt[1]; bus1.b = tt[0]; bus1.cin = tt[2];
            cycle();
        end

        // Hold: capture 1+0+0 then keep in_valid low while the operands wander.
        bus1.a = 1'b1; bus1.b = 1'b0; bus1.cin = 1'b0;
        cycle();
        bus1.in_valid = 1'b0;
        hold_toggle = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hold_toggle = ~hold_toggle;
            bus1.a = hold_toggle; bus1.b = ~hold_toggle; bus1.cin = 1'bx;
            cycle();
            check_eq("hold_sum", 64'(bus1.sum), 64'h1);
            check_eq("hold_carry", 64'(bus1.carry), 64'h0);
            check_eq("hold_ov", 64'(bus1.out_valid), 64'h0);
        end
        bus1.cin = 1'b0;

        // Full-width ripple and the two corner operands.
        drive8(1'b1, 8'hFF, 8'h00, 1'b1);
        cycle();
        check_eq("rip_ff00_sum", 64'(bus8.sum), 64'h00);
        check_eq("rip_ff00_carry", 64'(bus8.carry), 64'h1);
        drive8(1'b1, 8'hFF, 8'hFF, 1'b1);
        cycle();
        check_eq("rip_ffff_sum", 64'(bus8.sum), 64'hFF);
        check_eq("rip_ffff_carry", 64'(bus8.carry), 64'h1);
        drive8(1'b1, 8'h00, 8'h00, 1'b0);
        cycle();
        check_eq("zero_sum", 64'(bus8.sum), 64'h00);
        check_eq("zero_carry", 64'(bus8.carry), 64'h0);

        // Mid-stream reset on a steady 0F+01 stream.
        drive8(1'b1, 8'h0F, 8'h01, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("mid_pre_sum", 64'(bus8.sum), 64'h10);
        end
        rst = 1'b1;
        cycle();
        check_eq("mid_rst_sum", 64'(bus8.sum), 64'h00);
        check_eq("mid_rst_ov", 64'(bus8.out_valid), 64'h0);
        rst = 1'b0;
        cycle();
        check_eq("mid_post_sum", 64'(bus8.sum), 64'h10);
        check_eq("mid_post_ov", 64'(bus8.out_valid), 64'h1);
        cycle();

        // Random vectors on both widths; idle cycles carry unknown operands.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                drive8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
            end else begin
                drive8(1'b0, 8'hxx, 8'($urandom), 1'bx);
            end
            bus1.in_valid = 1'($urandom_range(0, 1));
            bus1.a = 1'($urandom); bus1.b = 1'($urandom); bus1.cin = 1'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
